// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: register addresses,
// source bit positions, vector constants and FSM state encodings.
package interrupt_controller_pkg;

  localparam int NUM_SOURCES = 5;

  // Register addresses on the MCU bus.
  localparam logic [15:0] IF_ADDR = 16'hFF0F;
  localparam logic [15:0] IE_ADDR = 16'hFFFF;

  // Source bit indices inside IF/IE; bit 0 has the highest priority.
  localparam int SRC_VBLANK   = 0;
  localparam int SRC_LCD_STAT = 1;
  localparam int SRC_TIMER    = 2;
  localparam int SRC_SERIAL   = 3;
  localparam int SRC_JOYPAD   = 4;

  // Restart vectors presented to the CPU.
  localparam logic [7:0] VEC_VBLANK   = 8'h40;
  localparam logic [7:0] VEC_LCD_STAT = 8'h48;
  localparam logic [7:0] VEC_TIMER    = 8'h50;
  localparam logic [7:0] VEC_SERIAL   = 8'h58;
  localparam logic [7:0] VEC_JOYPAD   = 8'h60;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/interrupt_priority_encoder.sv
// Fixed-priority encoder: picks the lowest-numbered pending source and
// returns its index and restart vector.
module interrupt_priority_encoder
  import interrupt_controller_pkg::*;
(
  input  logic [NUM_SOURCES-1:0] pending,
  output logic                   valid,
  output logic [2:0]             index,
  output logic [7:0]             vector
);

  // Scan from the lowest-priority bit down so the lowest set bit wins.
  always_comb begin
    // NOTE: every output gets a default before any condition, so no path
    // leaves a value unassigned and no latch is inferred.
    valid  = 1'b0;
    index  = 3'd0;
    vector = 8'h00;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (pending[i]) begin
        valid = 1'b1;
        index = 3'(i);
      end
    end
    if (valid) begin
      case (index)
        3'(SRC_VBLANK):   vector = VEC_VBLANK;
        3'(SRC_LCD_STAT): vector = VEC_LCD_STAT;
        3'(SRC_TIMER):    vector = VEC_TIMER;
        3'(SRC_SERIAL):   vector = VEC_SERIAL;
        default:          vector = VEC_JOYPAD;
      endcase
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: IF/IE registers, IME with delayed EI, and a
// request/acknowledge handshake towards the CPU.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iTick,
  input  logic                  iIrqVblank,
  input  logic                  iIrqLcdStat,
  input  logic                  iIrqTimer,
  input  logic                  iIrqSerial,
  input  logic                  iIrqJoypad,
  input  logic [ADDR_WIDTH-1:0] iMcuAddr,
  input  logic                  iMcuWriteEnable,
  input  logic [7:0]            iMcuWriteData,
  output logic [7:0]            oMcuReadData,
  input  logic                  iEI,
  input  logic                  iDI,
  input  logic                  iRETI,
  input  logic                  iIntAck,
  output logic                  oIntRequest,
  output logic [7:0]            oIntVector,
  output logic                  oWake
);

  logic [NUM_SOURCES-1:0] if_q, if_d;
  logic [7:0]             ie_q, ie_d;
  logic                   ime_q, ime_d;
  logic                   ei_pending_q, ei_pending_d;
  irq_state_e             state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             vec_q, vec_d;

  logic [NUM_SOURCES-1:0] src_pulse;
  logic [NUM_SOURCES-1:0] pending;
  logic                   pend_valid;
  logic [2:0]             pend_index;
  logic [7:0]             pend_vector;
  logic                   if_sel, ie_sel, ack;

  assign src_pulse = {iIrqJoypad, iIrqSerial, iIrqTimer, iIrqLcdStat, iIrqVblank};
  assign if_sel    = (iMcuAddr == ADDR_WIDTH'(IF_ADDR));
  assign ie_sel    = (iMcuAddr == ADDR_WIDTH'(IE_ADDR));
  assign pending   = if_q & ie_q[NUM_SOURCES-1:0];
  assign ack       = (state_q == ST_REQ) && iIntAck;

  assign oWake        = |pending;
  assign oMcuReadData = if_sel ? {3'b111, if_q} :
                        ie_sel ? ie_q : 8'h00;

  interrupt_priority_encoder u_prio (
    .pending (pending),
    .valid   (pend_valid),
    .index   (pend_index),
    .vector  (pend_vector)
  );

  // Next values of IF, IE, IME and the EI delay flag; later lines take priority.
  always_comb begin
    if_d         = if_q;
    ie_d         = ie_q;
    ime_d        = ime_q;
    ei_pending_d = ei_pending_q;

    if (iMcuWriteEnable && if_sel) if_d = iMcuWriteData[NUM_SOURCES-1:0];
    if (iMcuWriteEnable && ie_sel) ie_d = iMcuWriteData;
    if (ack) if_d[idx_q] = 1'b0;
    // Hardware requests are ORed in last so they beat both writes and ack clears.
    if_d = if_d | src_pulse;

    // EI takes effect on the first instruction boundary after its own cycle.
    if (ei_pending_q && iTick) begin
      ime_d        = 1'b1;
      ei_pending_d = 1'b0;
    end
    if (iEI)   ei_pending_d = 1'b1;
    if (iRETI) ime_d = 1'b1;
    if (ack)   ime_d = 1'b0;
    if (iDI) begin
      ime_d        = 1'b0;
      ei_pending_d = 1'b0;
    end
  end

  // Request FSM next state and CPU-facing outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    vec_d       = vec_q;
    oIntRequest = 1'b0;
    oIntVector  = 8'h00;
    unique case (state_q)
      ST_IDLE: begin
        if (ime_q && pend_valid) begin
          state_d = ST_REQ;
          idx_d   = pend_index;
          vec_d   = pend_vector;
        end
      end
      ST_REQ: begin
        oIntRequest = 1'b1;
        oIntVector  = vec_q;
        if (iIntAck) begin
          state_d = ST_SERVICE;
        end else if (!if_q[idx_q] || !ime_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (iTick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      if_q         <= '0;
      ie_q         <= 8'h00;
      ime_q        <= 1'b0;
      ei_pending_q <= 1'b0;
      state_q      <= ST_IDLE;
      idx_q        <= 3'd0;
      vec_q        <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      if_q         <= if_d;
      ie_q         <= ie_d;
      ime_q        <= ime_d;
      ei_pending_q <= ei_pending_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      vec_q        <= vec_d;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic, with a
// behavioural model feeding a scoreboard that a monitor drains every cycle.
`timescale 1ns/1ps
module tb_interrupt_controller;

  localparam logic [15:0] IF_A    = 16'hFF0F;
  localparam logic [15:0] IE_A    = 16'hFFFF;
  localparam logic [15:0] OTHER_A = 16'hC000;

  logic        iClock = 1'b0;
  logic        iReset = 1'b0;
  logic        iTick = 1'b0;
  logic        iIrqVblank = 1'b0, iIrqLcdStat = 1'b0, iIrqTimer = 1'b0;
  logic        iIrqSerial = 1'b0, iIrqJoypad = 1'b0;
  logic [15:0] iMcuAddr = 16'h0000;
  logic        iMcuWriteEnable = 1'b0;
  logic [7:0]  iMcuWriteData = 8'h00;
  logic [7:0]  oMcuReadData;
  logic        iEI = 1'b0, iDI = 1'b0, iRETI = 1'b0, iIntAck = 1'b0;
  logic        oIntRequest;
  logic [7:0]  oIntVector;
  logic        oWake;

  always #5 iClock = ~iClock;

  interrupt_controller #(.ADDR_WIDTH(16)) dut (
    .iClock          (iClock),
    .iReset          (iReset),
    .iTick           (iTick),
    .iIrqVblank      (iIrqVblank),
    .iIrqLcdStat     (iIrqLcdStat),
    .iIrqTimer       (iIrqTimer),
    .iIrqSerial      (iIrqSerial),
    .iIrqJoypad      (iIrqJoypad),
    .iMcuAddr        (iMcuAddr),
    .iMcuWriteEnable (iMcuWriteEnable),
    .iMcuWriteData   (iMcuWriteData),
    .oMcuReadData    (oMcuReadData),
    .iEI             (iEI),
    .iDI             (iDI),
    .iRETI           (iRETI),
    .iIntAck         (iIntAck),
    .oIntRequest     (oIntRequest),
    .oIntVector      (oIntVector),
    .oWake           (oWake)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [4:0] m_if;
  logic [7:0] m_ie;
  bit         m_ime, m_ei_armed, m_presenting, m_serving;
  int         m_src;
  int         cyc = 0;

  typedef struct {
    int         cyc;
    logic       req;
    logic [7:0] vec;
    logic       wake;
    logic [7:0] rd;
  } exp_t;
  exp_t exp_q[$];

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_step();
    logic [4:0] pulses, next_if, old_pend;
    bit         ack;
    int         first;
    if (iReset) begin
      m_if = '0; m_ie = '0; m_ime = 0; m_ei_armed = 0;
      m_presenting = 0; m_serving = 0; m_src = 0;
      return;
    end
    pulses   = {iIrqJoypad, iIrqSerial, iIrqTimer, iIrqLcdStat, iIrqVblank};
    old_pend = m_if & m_ie[4:0];
    ack      = m_presenting && iIntAck;

    next_if = (iMcuWriteEnable && iMcuAddr == IF_A) ? iMcuWriteData[4:0] : m_if;
    if (ack) next_if = next_if & ~(5'd1 << m_src);
    next_if = next_if | pulses;

    // Presentation decisions use the state as it was before this edge.
    if (!m_presenting && !m_serving) begin
      if (m_ime && old_pend != 0) begin
        first = -1;
        for (int i = 4; i >= 0; i--) if (old_pend[i]) first = i;
        m_src = first;
        m_presenting = 1;
      end
    end else if (m_presenting) begin
      if (ack) begin
        m_presenting = 0;
        m_serving = 1;
      end else if (!m_if[m_src] || !m_ime) begin
        m_presenting = 0;
      end
    end else if (iTick) begin
      m_serving = 0;
    end

    if (m_ei_armed && iTick) begin m_ime = 1; m_ei_armed = 0; end
    if (iEI)   m_ei_armed = 1;
    if (iRETI) m_ime = 1;
    if (ack)   m_ime = 0;
    if (iDI)   begin m_ime = 0; m_ei_armed = 0; end

    if (iMcuWriteEnable && iMcuAddr == IE_A) m_ie = iMcuWriteData;
    m_if = next_if;
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.cyc  = cyc;
    e.req  = m_presenting;
    e.vec  = m_presenting ? 8'(64 + 8 * m_src) : 8'h00;
    e.wake = (m_if & m_ie[4:0]) != 0;
    if (iMcuAddr == IF_A)      e.rd = {3'b111, m_if};
    else if (iMcuAddr == IE_A) e.rd = m_ie;
    else                       e.rd = 8'h00;
    return e;
  endfunction

  // One clock: model follows the edge, expectation is queued, strobes drop.
  task automatic cycle();
    @(posedge iClock);
    model_step();
    cyc++;
    exp_q.push_back(model_outputs());
    @(negedge iClock);
    iReset = 0; iTick = 0; iEI = 0; iDI = 0; iRETI = 0; iIntAck = 0;
    iIrqVblank = 0; iIrqLcdStat = 0; iIrqTimer = 0; iIrqSerial = 0; iIrqJoypad = 0;
    iMcuWriteEnable = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    iMcuAddr = a; iMcuWriteData = d; iMcuWriteEnable = 1;
    cycle();
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [7:0] exp);
    iMcuAddr = a;
    #1;
    check(name, oMcuReadData, exp);
  endtask

  task automatic out_check(input string name, input logic req, input logic [7:0] vec);
    check({name, " request"}, oIntRequest, req);
    check({name, " vector"}, oIntVector, vec);
  endtask

  // Monitor: compares DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge iClock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("cycle %0d {req,vec,wake,rd}", e.cyc),
              {oIntRequest, oIntVector, oWake, oMcuReadData},
              {e.req, e.vec, e.wake, e.rd});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    iReset = 1; cycle();
    iReset = 1; cycle();
    out_check("reset", 1'b0, 8'h00);
    check("reset wake", oWake, 1'b0);
    rd_check("reset IF read", IF_A, 8'hE0);
    rd_check("reset IE read", IE_A, 8'h00);

    // Timer request after EI + tick, two-cycle latency, ack clears IF and IME.
    wr(IE_A, 8'h04);
    iEI = 1; cycle();
    iTick = 1; cycle();
    iIrqTimer = 1; cycle();
    out_check("timer latency 1", 1'b0, 8'h00);
    cycle();
    out_check("timer latency 2", 1'b1, 8'h50);
    iIntAck = 1; cycle();
    rd_check("timer ack IF", IF_A, 8'hE0);
    iTick = 1; cycle();
    wr(IF_A, 8'h04);
    cycle(); cycle();
    out_check("IME cleared by ack", 1'b0, 8'h00);
    check("IME cleared wake", oWake, 1'b1);
    wr(IF_A, 8'h00);

    // Software-written IF, priority, RETI re-enable.
    wr(IE_A, 8'h1F);
    iRETI = 1; cycle();
    wr(IF_A, 8'h14);
    cycle();
    out_check("IF 0x14 first", 1'b1, 8'h50);
    iIntAck = 1; cycle();
    iTick = 1; cycle();
    iRETI = 1; cycle();
    cycle();
    out_check("after RETI", 1'b1, 8'h60);
    iIrqVblank = 1; cycle();
    cycle();
    out_check("latched vector held", 1'b1, 8'h60);
    iIntAck = 1; iIrqJoypad = 1; cycle();
    rd_check("ack vs pulse same bit", IF_A, 8'hF1);
    iTick = 1; cycle();
    wr(IF_A, 8'h00);

    // EI delay and DI cancelling a pending EI.
    wr(IE_A, 8'h01);
    iIrqVblank = 1; cycle();
    iEI = 1; cycle();
    cycle(); cycle();
    out_check("EI before tick", 1'b0, 8'h00);
    iTick = 1; cycle();
    cycle();
    out_check("EI after tick", 1'b1, 8'h40);
    iIntAck = 1; cycle();
    iTick = 1; cycle();
    iIrqVblank = 1; iEI = 1; cycle();
    iDI = 1; cycle();
    iTick = 1; cycle();
    cycle(); cycle();
    out_check("DI cancels EI", 1'b0, 8'h00);
    check("DI cancels EI wake", oWake, 1'b1);

    // Wake without IME.
    wr(IF_A, 8'h00);
    iIrqVblank = 1; cycle();
    out_check("wake only", 1'b0, 8'h00);
    check("wake only wake", oWake, 1'b1);
    rd_check("wake only IF", IF_A, 8'hE1);
    wr(IF_A, 8'h00);

    // Pulse beats a same-cycle IF write; software clear withdraws a request.
    iMcuAddr = IF_A; iMcuWriteData = 8'h00; iMcuWriteEnable = 1; iIrqTimer = 1; cycle();
    rd_check("write vs pulse", IF_A, 8'hE4);
    iRETI = 1; cycle();
    wr(IE_A, 8'h04);
    cycle();
    out_check("withdraw start", 1'b1, 8'h50);
    wr(IF_A, 8'h00);
    cycle();
    out_check("withdrawn", 1'b0, 8'h00);
    iIntAck = 1; cycle();
    rd_check("stray ack IF", IF_A, 8'hE0);
    iIrqTimer = 1; cycle();
    cycle();
    out_check("IME kept after stray ack", 1'b1, 8'h50);
    iIntAck = 1; cycle();

    // Reset while servicing.
    iReset = 1; cycle();
    out_check("reset in service", 1'b0, 8'h00);
    check("reset in service wake", oWake, 1'b0);
    rd_check("reset in service IE", IE_A, 8'h00);
    rd_check("reset in service IF", IF_A, 8'hE0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 1500; n++) begin
      iReset      = ($urandom_range(0, 299) == 0);
      iTick       = ($urandom_range(0, 2) == 0);
      iIrqVblank  = ($urandom_range(0, 11) == 0);
      iIrqLcdStat = ($urandom_range(0, 11) == 0);
      iIrqTimer   = ($urandom_range(0, 11) == 0);
      iIrqSerial  = ($urandom_range(0, 11) == 0);
      iIrqJoypad  = ($urandom_range(0, 11) == 0);
      iEI         = ($urandom_range(0, 9) == 0);
      iDI         = ($urandom_range(0, 29) == 0);
      iRETI       = ($urandom_range(0, 14) == 0);
      iIntAck     = m_presenting ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0, 1:    iMcuAddr = IF_A;
        2:       iMcuAddr = IE_A;
        default: iMcuAddr = OTHER_A;
      endcase
      iMcuWriteEnable = ($urandom_range(0, 9) == 0);
      iMcuWriteData   = 8'($urandom);
      cycle();
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge iClock);
    check("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter: ADDR_WIDTH, 16, MCU address bus width.
REQ-002 Port: iClock  in  1  system clock; all logic on its rising edge.
REQ-003 Port: iReset  in  1  reset, synchronous and active-high.
REQ-004 Port: iTick  in  1  instruction-boundary strobe from CPU, one cycle wide.
REQ-005 Port: iIrqVblank, iIrqLcdStat, iIrqTimer, iIrqSerial, iIrqJoypad  in  1 each  source request pulses; iIrqTimer is driven by the timers block's oInterrupt0x50.
REQ-006 Port: iMcuAddr  in  ADDR_WIDTH  register access address.
REQ-007 Port: iMcuWriteEnable  in  1  write strobe.
REQ-008 Port: iMcuWriteData  in  8  write data.
REQ-009 Port: oMcuReadData  out  8  read data for IF/IE; 0x00 for other addresses.
REQ-010 Port: iEI, iDI, iRETI  in  1 each  CPU decode strobes, one cycle wide.
REQ-011 Port: iIntAck  in  1  CPU accepts the presented interrupt.
REQ-012 Port: oIntRequest  out  1  interrupt presented to CPU.
REQ-013 Port: oIntVector  out  8  vector: 0x40, 0x48, 0x50, 0x58 or 0x60.
REQ-014 Port: oWake  out  1  HALT exit, |(IF & IE[4:0]) regardless of IME.

Function
REQ-015 IF register, 5 bits at 0xFF0F: bit n is set by a one-cycle pulse on source n (0 vblank .. 4 joypad), independent of IE and IME.
REQ-016 IE register, 8 bits at 0xFFFF; only bits [4:0] gate interrupts.
REQ-017 Reads are combinational: IF reads {3'b111, IF}; IE reads all 8 bits.
REQ-018 A write to IF or IE takes effect on the next edge.
REQ-019 Same-cycle source pulse and IF write: the written value is ORed with the pulse, so the hardware request wins.
REQ-020 Pending = IF & IE[4:0]; priority is fixed, bit 0 highest; vector = 0x40 + 8*index.
REQ-021 IME flag:
  - iDI clears IME and any pending EI immediately.
  - iEI sets an EI-pending flag; IME becomes 1 on the next iTick after the iEI cycle (one-instruction delay).
  - iRETI sets IME on the next edge.
REQ-022 FSM state IDLE: oIntRequest=0. Go to REQ when IME=1 and Pending!=0; the vector index is latched on entry.
REQ-023 FSM state REQ: oIntRequest=1 and oIntVector = latched vector.
  - iIntAck: clear the latched IF bit, clear IME, go to SERVICE.
  - If the latched bit is cleared by software or IME drops before ack: go to IDLE, no IF change.
REQ-024 FSM state SERVICE: oIntRequest=0; return to IDLE on iTick.
REQ-025 Same-cycle ack clear and new pulse on the same source: the bit ends set.
REQ-026 A higher-priority source arriving in REQ does not change the latched vector.
REQ-027 iIntAck outside REQ is ignored.
REQ-028 Latency: source pulse to oIntRequest=1 is 2 cycles when IME=1 and the IE bit is set.

Reset
REQ-029 Reset values: IF=0, IE=0x00, IME=0, EI-pending=0, FSM=IDLE, oIntRequest=0, oIntVector=0x00, oWake=0.
REQ-030 Reset asserted mid-REQ or mid-SERVICE returns to IDLE next edge; in-flight requests are discarded.

Structure
REQ-031 The shared definitions file holds the IF/IE addresses, the vector constants, the source bit indices and the FSM state encodings.
REQ-032 A single combinational sub-module, interrupt_priority_encoder, maps the 5-bit pending vector to a valid flag, a 3-bit index and an 8-bit vector.

Verification
REQ-033 IE=0x04, EI then iTick, iIrqTimer pulse -> oIntRequest=1 two cycles later with vector 0x50; ack -> IF bit 2=0, IME=0.
REQ-034 IE=0x1F, IF written 0x14 with IME=1 -> vector 0x50; after ack and RETI -> vector 0x60 presented.
REQ-035 iEI with a vblank pending -> no request until the following iTick; iDI before that iTick -> no request at all.
REQ-036 IME=0, IE=0x01, vblank pulse -> oWake=1, oIntRequest=0, IF reads 0xE1.
REQ-037 IF write 0x00 in the same cycle as a timer pulse -> IF reads 0xE4; REQ with IF cleared by software before ack -> IDLE, no ack effect.
REQ-038 Reset asserted in SERVICE -> all outputs at reset values next cycle; IE reads 0x00.
